// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    // Branch targets are forced onto a word boundary before fetching.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-port, redirect and decode-side handshake bundle of the fetch queue.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  memAddress;
    logic             memReadEnable;
    logic [XLEN-1:0]  memDataIn;
    logic             memSuccess;
    logic             redirect;
    logic [XLEN-1:0]  redirectTarget;
    logic             consume;
    logic             outValid;
    logic [XLEN-1:0]  outInstruction;
    logic [XLEN-1:0]  outProgramCounter;
    logic [CNT_W-1:0] count;

    modport master (
        output memAddress, memReadEnable, outValid, outInstruction,
               outProgramCounter, count,
        input  memDataIn, memSuccess, redirect, redirectTarget, consume
    );

    modport slave (
        input  memAddress, memReadEnable, outValid, outInstruction,
               outProgramCounter, count,
        output memDataIn, memSuccess, redirect, redirectTarget, consume
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Circular buffer with occupancy count, synchronous clear and active-low sync reset.
module fetch_queue_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = logic [63:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  entry_t                 i_data,
    output entry_t                 o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_push  = i_push && (!w_full || i_pop);
    assign w_pop   = i_pop && !o_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !i_clear && w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues word fetches, buffers {pc, instr}.
// Optional zero-latency bypass of an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      r_fetch_pc;
    logic             w_mem_req;
    logic             w_push;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_new_entry;
    fetch_entry_t     w_head;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic             w_bypass;
`endif

    // Request whenever there is room now or room made by this cycle's consume.
    assign w_mem_req   = rst && !bus.redirect &&
                         ((w_count < CNT_W'(DEPTH)) || bus.consume);
    assign w_push      = w_mem_req && bus.memSuccess;
    assign w_new_entry = '{pc: r_fetch_pc, instruction: bus.memDataIn};

`ifdef FETCH_QUEUE_BYPASS_EN
    // An arriving word consumed straight out of an empty queue never gets stored.
    assign w_bypass    = w_fifo_empty && w_push;
    assign w_fifo_push = w_push && !(w_bypass && bus.consume);
`else
    assign w_fifo_push = w_push;
`endif
    assign w_fifo_pop  = bus.consume && !w_fifo_empty;

    fetch_queue_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.redirect),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (w_new_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_fifo_empty)
    );

    // Fetch PC: reset beats redirect, redirect beats sequential advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (bus.redirect) begin
            r_fetch_pc <= align_pc(bus.redirectTarget);
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
        end
    end

    always_comb begin
        bus.outValid          = 1'b0;
        bus.outInstruction    = NOP_INSTRUCTION;
        bus.outProgramCounter = '0;
        if (!w_fifo_empty) begin
            bus.outValid          = 1'b1;
            bus.outInstruction    = w_head.instruction;
            bus.outProgramCounter = w_head.pc;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (w_bypass) begin
            bus.outValid          = 1'b1;
            bus.outInstruction    = bus.memDataIn;
            bus.outProgramCounter = r_fetch_pc;
        end
`endif
    end

    assign bus.memAddress    = r_fetch_pc;
    assign bus.memReadEnable = w_mem_req;
    assign bus.count         = w_count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the MMU instruction port and the IF/ID barrier. It owns the fetch program counter and issues sequential word fetches to instruction memory. Fetched {pc, instruction} pairs are buffered in a small circular queue, and the head entry is presented to the decode stage. On a branch redirect it flushes the queue and restarts fetch at the target, which decouples instruction-memory wait states from pipeline stalls.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h00000000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-low
- memAddress  out  32  instruction memory address (= fetchPc)
- memReadEnable  out  1  fetch request this cycle
- memDataIn  in  32  instruction word returned by the MMU
- memSuccess  in  1  memDataIn is valid for memAddress this cycle
- redirect  in  1  branch taken in EX (shouldBranch)
- redirectTarget  in  32  branch target (branchTarget)
- consume  in  1  decode stage accepts the head entry this cycle
- outValid  out  1  head entry present
- outInstruction  out  32  head instruction; NOP 32'h00000013 when !outValid
- outProgramCounter  out  32  head pc; 0 when !outValid
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetchPc (32b), rdPtr/wrPtr ($clog2(DEPTH) bits, wrap mod DEPTH), count.
- Reset (rst=0 at edge): fetchPc=RESET_PC, pointers=0, count=0. Outputs: outValid=0, outInstruction=NOP, outProgramCounter=0, memAddress=RESET_PC, memReadEnable=0 during reset cycle.
- memReadEnable = rst && !redirect && (count<DEPTH || consume).
- push = memReadEnable && memSuccess. On push: write {fetchPc, memDataIn} at wrPtr; wrPtr++; fetchPc += 4 (32-bit wrap, 32'hFFFFFFFC → 0).
- pop = consume && outValid. On pop: rdPtr++. consume while empty is ignored.
- count_next = count + push − pop. Simultaneous push+pop at full holds count=DEPTH.
- Redirect has priority over everything: pointers and count cleared, fetchPc = {redirectTarget[31:2], 2'b00}, no push, no pop.
- memSuccess low: fetchPc held, request re-issued next cycle (address stable until success).
- Reset during pending request or redirect: reset wins.

## Timing
- Fetch-to-output latency: push at edge N → outValid=1 after edge N (entry visible cycle N+1).
- Redirect asserted in cycle N → cycle N+1: outValid=0, memAddress=target, memReadEnable=1; earliest target instruction at decode in cycle N+2.
- Full queue with no consume: memReadEnable=0, memAddress=fetchPc held.
- All outputs except memReadEnable are purely registered or a mux of registered state.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0 and push occurs, outValid=1 combinationally in the same cycle, with outInstruction=memDataIn and outProgramCounter=fetchPc. If consume is also high in that cycle, the entry is not written and count stays 0. Zero-latency fetch.
- Undefined: no combinational path from memDataIn/memSuccess to out*; one-cycle latency as in Timing.

## Structure
- Package fetch_queue_pkg: typedef fetch_entry_t {pc[31:0], instruction[31:0]}, INSTR_BYTES=4, NOP_INSTRUCTION=32'h00000013.
- Sub-module sync_fifo: storage array, pointers, and count, with synchronous clear; parameterized on DEPTH and entry type. It is instantiated once.
- Top level holds fetchPc, the request logic, redirect priority, and the bypass mux.

## Test plan
- Reset then memSuccess=1 constantly, consume=0: memAddress 0,4,8,12. Then memReadEnable=0, count=4, head pc=0.
- Steady flow with memSuccess=1 and consume=1: one instruction per cycle with pc incrementing by 4; count stays at 1 (0 with bypass).
- memSuccess low for 3 cycles at pc=8: memAddress holds 8 and no push; entry pc=8 is pushed on the 4th cycle.
- Full queue plus redirect to 32'h00000103: next cycle count=0, outValid=0, memAddress=32'h00000100; the next output pc=0x100.
- Full queue with consume=1 and memSuccess=1 in the same cycle: count stays 4, head advances by one entry, tail pc = old tail+4.
- rst=0 asserted while count=3 and a request is pending: next cycle count=0, memAddress=RESET_PC, outInstruction=NOP.
